// File: rtl/tdm_pkg.sv
// ----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the TDM receive demultiplexer.
//   state_t    : receive FSM encoding (WAIT_SYNC = 1'b0, RECV = 1'b1)
//   slot_width : width of the slot index for an N-slot frame (at least 1)
// ----------------------------------------------------------------------------
package tdm_pkg;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        RECV      = 1'b1
    } state_t;

    // Width needed to hold slot indices 0..n-1; never narrower than one bit.
    function automatic int slot_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage : tdm_pkg

// File: rtl/tdm_slot_cnt.sv
// ----------------------------------------------------------------------------
// tdm_slot_cnt
// Loadable modulo-N slot counter for the TDM receiver.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (slot -> 0)
//   clr        : force slot to 0 (frame complete)
//   load1      : force slot to 1 (sync beat captured as slot 0)
//   inc        : advance slot by one, wrapping at N-1
//   slot       : index of the next slot expected
//   last       : slot == N-1
// Priority: clr > load1 > inc.
// ----------------------------------------------------------------------------
module tdm_slot_cnt
    import tdm_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = slot_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load1,
    input  logic          inc,
    output logic [SW-1:0] slot,
    output logic          last
);

    localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

    logic [SW-1:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= SW'(1);
        end else if (inc) begin
            // Explicit wrap keeps non-power-of-two N inside 0..N-1.
            cnt <= (cnt == LAST_IDX) ? '0 : cnt + SW'(1);
        end
    end

    assign slot = cnt;
    assign last = (cnt == LAST_IDX);

endmodule : tdm_slot_cnt

// File: rtl/tdm_demux_rx.sv
// ----------------------------------------------------------------------------
// tdm_demux_rx
// Receive end of a TDM link: collects N W-bit slots, framed by a sync pulse on
// slot 0, into a shadow buffer and publishes the whole frame atomically.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   sync       : start-of-frame marker (qualified by in_valid)
//   in_valid   : in_data carries a slot this cycle
//   in_data    : slot payload (W bits)
//   out_data   : published frame, lane k at [k*W +: W]; holds between publishes
//   out_valid  : one-cycle pulse when out_data is updated
//   slot       : index of the next slot expected
//   frame_err  : one-cycle pulse when sync arrives before the frame completed
// Optional (macro TDM_PARITY_EN):
//   in_par     : even parity over in_data, sampled with in_valid
//   par_err    : one-cycle pulse instead of out_valid when any beat of the
//                completed frame had bad parity; out_data is then unchanged
// ----------------------------------------------------------------------------
module tdm_demux_rx
    import tdm_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = slot_width(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sync,
    input  logic           in_valid,
    input  logic [W-1:0]   in_data,
`ifdef TDM_PARITY_EN
    input  logic           in_par,
    output logic           par_err,
`endif
    output logic [N*W-1:0] out_data,
    output logic           out_valid,
    output logic [SW-1:0]  slot,
    output logic           frame_err
);

    state_t         state;
    logic [W-1:0]   shadow [N];
    logic [N*W-1:0] frame_next;
    logic           last;
    logic           cnt_clr;
    logic           cnt_load1;
    logic           cnt_inc;

    // A sync beat always restarts the frame, from either state.
    assign cnt_load1 = in_valid && sync;
    assign cnt_clr   = (state == RECV) && in_valid && !sync && last;
    assign cnt_inc   = (state == RECV) && in_valid && !sync && !last;

    tdm_slot_cnt #(.N(N), .SW(SW)) u_slot_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .slot  (slot),
        .last  (last)
    );

    // Completed frame: shadow lanes with the final beat merged into lane N-1,
    // so the publish happens on the same edge that samples the last slot.
    // NOTE: every always_comb output is given a full default first so no latch
    // can be inferred.
    always_comb begin
        frame_next = '0;
        for (int k = 0; k < N; k++) begin
            frame_next[k*W +: W] = shadow[k];
        end
        frame_next[(N-1)*W +: W] = in_data;
    end

`ifdef TDM_PARITY_EN
    logic par_flag;
    logic beat_bad;

    // Even parity: in_par must equal the XOR of the payload bits.
    assign beat_bad = in_par != (^in_data);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= WAIT_SYNC;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            // NOTE: the shadow buffer is a small register array, not a RAM, so
            // clearing it on reset is cheap and keeps reset state fully defined.
            for (int k = 0; k < N; k++) begin
                shadow[k] <= '0;
            end
`ifdef TDM_PARITY_EN
            par_err   <= 1'b0;
            par_flag  <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
`ifdef TDM_PARITY_EN
            par_err   <= 1'b0;
`endif
            unique case (state)
                WAIT_SYNC: begin
                    // Beats without sync are dropped silently here.
                    if (in_valid && sync) begin
                        shadow[0] <= in_data;
                        state     <= RECV;
`ifdef TDM_PARITY_EN
                        par_flag  <= beat_bad;
`endif
                    end
                end

                RECV: begin
                    if (in_valid && sync) begin
                        // Short frame: drop it and resync on this beat.
                        frame_err <= 1'b1;
                        shadow[0] <= in_data;
`ifdef TDM_PARITY_EN
                        par_flag  <= beat_bad;
`endif
                    end else if (in_valid) begin
                        shadow[slot] <= in_data;
                        if (last) begin
                            state <= WAIT_SYNC;
`ifdef TDM_PARITY_EN
                            if (par_flag || beat_bad) begin
                                par_err <= 1'b1;
                            end else begin
                                out_data  <= frame_next;
                                out_valid <= 1'b1;
                            end
                            par_flag <= 1'b0;
`else
                            out_data  <= frame_next;
                            out_valid <= 1'b1;
`endif
                        end else begin
`ifdef TDM_PARITY_EN
                            par_flag <= par_flag || beat_bad;
`endif
                        end
                    end
                end

                default: state <= WAIT_SYNC;
            endcase
        end
    end

endmodule : tdm_demux_rx

// File: tb/tb_tdm_demux_rx.sv
// ----------------------------------------------------------------------------
// tb_tdm_demux_rx
// Scoreboard bench for tdm_demux_rx (N=4, W=8). Stimulus pushes expected
// output events (publish / framing error / parity error) into a queue; a
// monitor on the falling clock edge pops and compares whenever the DUT
// presents an event, and otherwise checks that out_data is held.
// Build with TDM_PARITY_EN defined to also exercise the parity option.
// ----------------------------------------------------------------------------
module tb_tdm_demux_rx;

    localparam int N = 4;
    localparam int W = 8;

    typedef enum int { EV_PUB = 0, EV_ERR = 1, EV_PAR = 2 } ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] data;
    } ev_t;

    logic           clk;
    logic           rst_n;
    logic           sync;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic [N*W-1:0] out_data;
    logic           out_valid;
    logic [1:0]     slot;
    logic           frame_err;
`ifdef TDM_PARITY_EN
    logic           in_par;
    logic           par_err;
`endif

    tdm_demux_rx #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync      (sync),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef TDM_PARITY_EN
        .in_par    (in_par),
        .par_err   (par_err),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .slot      (slot),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ev_t         exp_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc    = 0;
    int          pub_last = 0;
    int          pub_prev = 0;
    logic [31:0] held = '0;
    logic        mon_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input ev_kind_t kind, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            ev_t      e;
            ev_kind_t kind_act;
            logic     ev_seen;
            logic     perr;
`ifdef TDM_PARITY_EN
            perr = par_err;
`else
            perr = 1'b0;
`endif
            check("valid_err_exclusive", {31'b0, out_valid & frame_err}, 32'd0);
            ev_seen  = out_valid | frame_err | perr;
            kind_act = out_valid ? EV_PUB : (frame_err ? EV_ERR : EV_PAR);
            if (ev_seen) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_event: got valid=%0b err=%0b par=%0b expected none (t=%0t)",
                             out_valid, frame_err, perr, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'(kind_act), 32'(e.kind));
                    if (e.kind == EV_PUB) begin
                        check("out_data", out_data, e.data);
                        held     = e.data;
                        pub_prev = pub_last;
                        pub_last = cyc;
                    end else begin
                        check("out_data_unchanged_on_error", out_data, held);
                    end
                end
            end else begin
                check("out_data_held", out_data, held);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic beat(input logic s, input logic [7:0] d, input logic bad);
        in_valid = 1'b1;
        sync     = s;
        in_data  = d;
`ifdef TDM_PARITY_EN
        in_par   = (^d) ^ bad;
`else
        if (bad) $display("note: parity corruption requested without TDM_PARITY_EN");
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sync     = 1'b0;
        in_data  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One full frame; lane i of f is slot i. bad_slot < 0 means clean parity.
    task automatic frame(input logic [31:0] f, input int gap, input int bad_slot);
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) begin
                if (bad_slot >= 0) push(EV_PAR, 32'd0);
                else               push(EV_PUB, f);
            end
            beat(i == 0, f[i*8 +: 8], i == bad_slot);
            check("slot_after_beat", 32'(slot), 32'((i + 1) % N));
            if (i == N - 1)
                check("out_valid_latency", {31'b0, out_valid}, {31'b0, bad_slot < 0});
            else if (gap > 0)
                idle(gap);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: got %0d pending events expected 0", exp_q.size());
            exp_q.delete();
        end
        idle(2);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n    = 1'b0;
        sync     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
`ifdef TDM_PARITY_EN
        in_par   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_data",  out_data, 32'd0);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_frame_err", {31'b0, frame_err}, 32'd0);
        check("reset_slot",      32'(slot), 32'd0);
`ifdef TDM_PARITY_EN
        check("reset_par_err",   {31'b0, par_err}, 32'd0);
`endif
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(1);

        // Straight frame
        frame(32'hA3A2A1A0, 0, -1);
        drain();

        // Same frame with 3-cycle gaps between beats
        frame(32'hA3A2A1A0, 3, -1);
        drain();

        // Junk beats without sync are ignored
        beat(1'b0, 8'h11, 1'b0);
        check("junk_slot", 32'(slot), 32'd0);
        beat(1'b0, 8'h22, 1'b0);
        check("junk_slot", 32'(slot), 32'd0);
        frame(32'h04030201, 0, -1);
        drain();

        // Early sync: AA, BB discarded, frame_err at the second sync
        beat(1'b1, 8'hAA, 1'b0);
        beat(1'b0, 8'hBB, 1'b0);
        check("short_frame_slot", 32'(slot), 32'd2);
        push(EV_ERR, 32'd0);
        frame(32'h40302010, 0, -1);
        drain();

        // Back-to-back frames, sync right after the last slot
        frame(32'h14131211, 0, -1);
        frame(32'h24232221, 0, -1);
        drain();
        check("back_to_back_spacing", 32'(pub_last - pub_prev), 32'd4);

        // Mid-frame reset: partial frame dropped, no publish
        beat(1'b1, 8'h55, 1'b0);
        beat(1'b0, 8'h66, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        held = '0;
        check("midreset_out_data",  out_data, 32'd0);
        check("midreset_slot",      32'(slot), 32'd0);
        check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        check("midreset_frame_err", {31'b0, frame_err}, 32'd0);
        rst_n = 1'b1;
        idle(3);

        // Recovery frame after reset
        frame(32'hC3C2C1C0, 0, -1);
        drain();

`ifdef TDM_PARITY_EN
        // Bad parity on slot 2: par_err, out_data keeps C3C2C1C0
        frame(32'hD3D2D1D0, 0, 2);
        drain();
        check("par_frame_held", out_data, 32'hC3C2C1C0);
        frame(32'hE3E2E1E0, 0, -1);
        drain();
`endif

        idle(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time %0t expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_tdm_demux_rx
